// File: rtl/abs_rr_scheduler.sv
// abs_rr_scheduler: round-robin sharing of one registered abs-value stage.
// Ports:
//   clk, rst_n (async reset, active HIGH despite the name)
//   req_valid/req_data/req_ready : N requesters, one-hot grant
//   rsp_valid/rsp_ready/rsp_data/rsp_id/rsp_ovf : tagged result
//   busy : operation in flight
module abs_rr_scheduler #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   req_ready,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [W-1:0]   rsp_data,
  output logic [IDW-1:0] rsp_id,
  output logic           rsp_ovf,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  state_t         r_state;
  state_t         w_next;
  logic [IDW-1:0] r_ptr;
  logic [W-1:0]   r_op;
  logic [IDW-1:0] r_id;

  logic           w_any;
  logic [IDW-1:0] w_gidx;
  logic [IDW-1:0] w_ptr_nxt;
  logic [W-1:0]   w_gdata;
  logic           w_take;

  // Rotating priority search. Walk offsets from high to low so the
  // smallest offset from r_ptr is the one that sticks.
  always_comb begin
    int unsigned idx;
    w_any  = 1'b0;
    w_gidx = '0;
    idx    = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(r_ptr) + k) % N;
      if (req_valid[idx]) begin
        w_any  = 1'b1;
        w_gidx = IDW'(idx);
      end
    end
  end

  assign w_gdata   = req_data[int'(w_gidx)*W +: W];
  assign w_ptr_nxt = (w_gidx == IDW'(N - 1)) ? '0 : w_gidx + 1'b1;
  assign w_take    = (r_state == IDLE) && w_any;

  // State register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_next = CALC;
      CALC:    w_next = HOLD;
      HOLD:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs. The grant is masked during reset so it reads zero while
  // rst_n is held even if requests are already pending.
  always_comb begin
    req_ready = '0;
    busy      = (r_state != IDLE);
    if (w_take && !rst_n) begin
      req_ready = N'(1) << w_gidx;
    end
  end

  // Datapath: operand capture, abs stage, and held response.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_ptr     <= '0;
      r_op      <= '0;
      r_id      <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_op  <= w_gdata;
            r_id  <= w_gidx;
            r_ptr <= w_ptr_nxt;
          end
        end
        CALC: begin
          // Negating MOST_NEG wraps back onto itself, which is exactly
          // its unsigned magnitude.
          rsp_data  <= r_op[W-1] ? (~r_op + W'(1)) : r_op;
          rsp_ovf   <= (r_op == MOST_NEG);
          rsp_id    <= r_id;
          rsp_valid <= 1'b1;
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_abs_rr_scheduler.sv
// Testbench for abs_rr_scheduler: table-driven single operations,
// directed multi-cycle sequences, and a scoreboarded reference model.
module tb_abs_rr_scheduler;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_data;
  logic [IDW-1:0] rsp_id;
  logic           rsp_ovf;
  logic           busy;

  abs_rr_scheduler #(.N(N), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mag(logic [7:0] op);
    int s;
    s = $signed(op);
    if (s < 0) s = -s;
    return s[7:0];
  endfunction

  function automatic int pick(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [7:0] data;
    logic [1:0] id;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   m_state = 0;  // 0 idle, 1 calc, 2 hold
  int   m_ptr   = 0;

  always @(negedge clk) begin
    logic [N-1:0] erdy;
    int g;
    exp_t e;
    if (rst_n) begin
      m_state = 0;
      m_ptr   = 0;
      sb.delete();
    end else begin
      erdy = '0;
      g    = pick(req_valid, m_ptr);
      if (m_state == 0 && g >= 0) erdy[g] = 1'b1;
      chk("sb req_ready", 32'(req_ready), 32'(erdy));
      chk("sb busy", 32'(busy), 32'(m_state != 0));
      chk("sb rsp_valid", 32'(rsp_valid), 32'(m_state == 2));
      if (m_state == 2) begin
        if (sb.size() == 0) begin
          chk("sb queue nonempty", 0, 1);
        end else begin
          chk("sb rsp_data", 32'(rsp_data), 32'(sb[0].data));
          chk("sb rsp_id", 32'(rsp_id), 32'(sb[0].id));
          chk("sb rsp_ovf", 32'(rsp_ovf), 32'(sb[0].ovf));
          if (rsp_ready) void'(sb.pop_front());
        end
        if (rsp_ready) m_state = 0;
      end else if (m_state == 1) begin
        m_state = 2;
      end else if (g >= 0) begin
        e.data = mag(req_data[g*W +: W]);
        e.id   = 2'(g);
        e.ovf  = (req_data[g*W +: W] == 8'h80);
        sb.push_back(e);
        m_ptr   = (g + 1) % N;
        m_state = 1;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    int         idx;
    logic [7:0] op;
    logic [7:0] exp_mag;
    logic       exp_ovf;
  } vec_t;

  vec_t tbl[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(string nm, output int t);
    t = 0;
    while (!rsp_valid && t < 10) begin
      tick();
      t++;
    end
    if (!rsp_valid) chk({nm, " rsp timeout"}, 0, 1);
  endtask

  task automatic do_op(string nm, int idx, logic [7:0] op,
                       logic [7:0] em, logic eo);
    int t;
    req_data = '0;
    req_data[idx*W +: W] = op;
    req_valid = N'(1) << idx;
    rsp_ready = 1'b1;
    #1;
    chk({nm, " grant"}, 32'(req_ready), 32'(N'(1) << idx));
    tick();
    req_valid = '0;
    #1;
    chk({nm, " ready low"}, 32'(req_ready), 0);
    chk({nm, " busy calc"}, 32'(busy), 1);
    wait_rsp(nm, t);
    chk({nm, " latency"}, t, 1);
    chk({nm, " busy hold"}, 32'(busy), 1);
    chk({nm, " data"}, 32'(rsp_data), 32'(em));
    chk({nm, " id"}, 32'(rsp_id), idx);
    chk({nm, " ovf"}, 32'(rsp_ovf), 32'(eo));
    tick();
    chk({nm, " valid drop"}, 32'(rsp_valid), 0);
    chk({nm, " busy idle"}, 32'(busy), 0);
  endtask

  initial begin
    int t;
    int last;
    logic [7:0] hd;
    logic [1:0] hid;
    logic [7:0] cont_mag[4];

    tbl[0] = '{0, 8'hF6, 8'h0A, 1'b0};
    tbl[1] = '{1, 8'h00, 8'h00, 1'b0};
    tbl[2] = '{2, 8'h80, 8'h80, 1'b1};
    tbl[3] = '{3, 8'h7F, 8'h7F, 1'b0};
    tbl[4] = '{0, 8'h01, 8'h01, 1'b0};
    tbl[5] = '{1, 8'h81, 8'h7F, 1'b0};
    tbl[6] = '{2, 8'hFF, 8'h01, 1'b0};
    tbl[7] = '{3, 8'h9C, 8'h64, 1'b0};

    cont_mag[0] = 8'h05;
    cont_mag[1] = 8'h01;
    cont_mag[2] = 8'h80;
    cont_mag[3] = 8'h7F;

    rst_n     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    #1;
    chk("reset rsp_valid", 32'(rsp_valid), 0);
    chk("reset rsp_data", 32'(rsp_data), 0);
    chk("reset rsp_id", 32'(rsp_id), 0);
    chk("reset rsp_ovf", 32'(rsp_ovf), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset req_ready", 32'(req_ready), 0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      do_op($sformatf("vec%0d", i), tbl[i].idx, tbl[i].op,
            tbl[i].exp_mag, tbl[i].exp_ovf);
    end

    // All four requesting continuously from ptr=0.
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    req_data  = {8'h7F, 8'h80, 8'hFF, 8'h05};
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    last = 0;
    for (int k = 0; k < 6; k++) begin
      wait_rsp("cont", t);
      chk("cont id", 32'(rsp_id), k % N);
      chk("cont data", 32'(rsp_data), 32'(cont_mag[k % N]));
      chk("cont ovf", 32'(rsp_ovf), 32'((k % N) == 2));
      if (k > 0) chk("cont interval", cyc - last, 3);
      last = cyc;
      if (k == 5) req_valid = '0;
      tick();
    end
    tick();

    // Wrap: grant 2 leaves ptr=3; then 1 and 3 compete.
    do_op("wrap pre", 2, 8'h10, 8'h10, 1'b0);
    req_data  = '0;
    req_data[1*W +: W] = 8'h90;
    req_data[3*W +: W] = 8'h11;
    req_valid = 4'b1010;
    #1;
    chk("wrap first", 32'(req_ready), 32'(4'b1000));
    tick();
    req_valid = 4'b0010;
    wait_rsp("wrap a", t);
    chk("wrap a id", 32'(rsp_id), 3);
    chk("wrap a data", 32'(rsp_data), 32'h11);
    tick();
    chk("wrap second", 32'(req_ready), 32'(4'b0010));
    tick();
    req_valid = '0;
    wait_rsp("wrap b", t);
    chk("wrap b id", 32'(rsp_id), 1);
    chk("wrap b data", 32'(rsp_data), 32'h70);
    tick();
    req_data[0*W +: W] = 8'h02;
    req_data[2*W +: W] = 8'h03;
    req_valid = 4'b0101;
    #1;
    chk("wrap ptr2", 32'(req_ready), 32'(4'b0100));
    tick();
    req_valid = 4'b0001;
    wait_rsp("wrap c", t);
    tick();
    chk("wrap ptr3 wraps", 32'(req_ready), 32'(4'b0001));
    tick();
    req_valid = '0;
    wait_rsp("wrap d", t);
    tick();

    // Backpressure with a competing request pending. ptr=1 here.
    rsp_ready = 1'b0;
    req_data  = '0;
    req_data[0*W +: W] = 8'h01;
    req_data[3*W +: W] = 8'hC8;
    req_valid = 4'b1001;
    #1;
    chk("bp grant", 32'(req_ready), 32'(4'b1000));
    tick();
    req_valid = 4'b0001;
    wait_rsp("bp", t);
    hd  = rsp_data;
    hid = rsp_id;
    chk("bp data", 32'(hd), 32'h38);
    chk("bp id", 32'(hid), 3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp hold valid", 32'(rsp_valid), 1);
      chk("bp hold data", 32'(rsp_data), 32'(hd));
      chk("bp hold id", 32'(rsp_id), 32'(hid));
      chk("bp hold ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp release valid", 32'(rsp_valid), 0);
    chk("bp next grant", 32'(req_ready), 32'(4'b0001));
    tick();
    req_valid = '0;
    wait_rsp("bp next", t);
    chk("bp next id", 32'(rsp_id), 0);
    tick();

    // Asynchronous reset while holding a response.
    rsp_ready = 1'b0;
    req_data  = '0;
    req_data[0*W +: W] = 8'h85;
    req_data[1*W +: W] = 8'h9C;
    req_data[2*W +: W] = 8'h33;
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0101;
    wait_rsp("ar", t);
    chk("ar in hold", 32'(busy), 1);
    #3;
    rst_n = 1'b1;
    #1;
    chk("ar rsp_valid", 32'(rsp_valid), 0);
    chk("ar busy", 32'(busy), 0);
    chk("ar rsp_data", 32'(rsp_data), 0);
    chk("ar rsp_id", 32'(rsp_id), 0);
    chk("ar rsp_ovf", 32'(rsp_ovf), 0);
    chk("ar req_ready", 32'(req_ready), 0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("ar first grant", 32'(req_ready), 32'(4'b0001));
    rsp_ready = 1'b1;
    tick();
    req_valid = '0;
    wait_rsp("ar post", t);
    chk("ar post id", 32'(rsp_id), 0);
    chk("ar post data", 32'(rsp_data), 32'h7B);
    tick();
    for (int i = 0; i < 4; i++) tick();
    chk("sb drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
